// File: rtl/rom_header_scanner.sv
// Snoops the ioctl ROM download, captures six candidate SNES internal headers
// and, once the download ends, scores them to pick the cartridge mapping.
`timescale 1ns/1ps
module rom_header_scanner #(
   parameter logic [24:0] HDR_OFS      = 25'h200,
   parameter int          MIN_SCORE    = 4,
   parameter logic [3:0]  DEF_ROM_SIZE = 4'hC
) (
   input  logic        clk_sys,
   input  logic        RESET,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [15:0] ioctl_dout,
   output logic [7:0]  rom_type,
   output logic [23:0] rom_mask,
   output logic [23:0] ram_mask,
   output logic        rom_pal,
   output logic        hdr_copier,
   output logic        hdr_valid,
   output logic        hdr_done,
   output logic [3:0]  best_score
);

   localparam logic [3:0] MIN_S = 4'(MIN_SCORE);

   typedef enum logic [1:0] {IDLE, CAPTURE, EVAL, DONE} state_t;

   function automatic logic [24:0] slot_base(input int s);
      logic [24:0] b;
      case (s % 3)
         0:       b = 25'h7FC0;
         1:       b = 25'hFFC0;
         default: b = 25'h40FFC0;
      endcase
      return (s >= 3) ? b + HDR_OFS : b;
   endfunction

   function automatic logic [3:0] mode_of(input logic [1:0] idx);
      case (idx)
         2'd0:    return 4'h0;
         2'd1:    return 4'h1;
         default: return 4'h5;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic        old_dl_q;
   logic [1:0]  idx_q, idx_d;
   logic [3:0]  best_q, best_d;
   logic [1:0]  best_idx_q, best_idx_d;
   logic [24:0] last_addr_q;
   logic        load_out;

   logic [7:0]  mode_q   [6];
   logic [7:0]  rsize_q  [6];
   logic [7:0]  ram_q    [6];
   logic [7:0]  region_q [6];
   logic [15:0] cmpl_q   [6];
   logic [15:0] csum_q   [6];
   logic [5:0]  seen_q;

   logic [5:0]  hit_mode, hit_rsize, hit_ram, hit_cmpl, hit_csum;

   logic rise, fall, clear_cap, cap_en;
   assign rise      = ~old_dl_q & ioctl_download;
   assign fall      = old_dl_q & ~ioctl_download;
   assign clear_cap = rise && (state_q != CAPTURE);
   assign cap_en    = (state_q == CAPTURE) && ioctl_wr;

   // Address decode per slot; odd addresses can never equal an even base+offset.
   for (genvar gi = 0; gi < 6; gi++) begin : g_slot
      localparam logic [24:0] B = slot_base(gi);
      assign hit_mode[gi]  = cap_en && (ioctl_addr == B + 25'h14);
      assign hit_rsize[gi] = cap_en && (ioctl_addr == B + 25'h16);
      assign hit_ram[gi]   = cap_en && (ioctl_addr == B + 25'h18);
      assign hit_cmpl[gi]  = cap_en && (ioctl_addr == B + 25'h1C);
      assign hit_csum[gi]  = cap_en && (ioctl_addr == B + 25'h1E);
   end

   always_ff @(posedge clk_sys) begin
      if (RESET || clear_cap) begin
         seen_q <= '0;
         for (int s = 0; s < 6; s++) begin
            mode_q[s]   <= '0;
            rsize_q[s]  <= '0;
            ram_q[s]    <= '0;
            region_q[s] <= '0;
            cmpl_q[s]   <= '0;
            csum_q[s]   <= '0;
         end
      end else begin
         for (int s = 0; s < 6; s++) begin
            if (hit_mode[s])  mode_q[s]  <= ioctl_dout[15:8];
            if (hit_rsize[s]) rsize_q[s] <= ioctl_dout[15:8];
            if (hit_ram[s]) begin
               ram_q[s]    <= ioctl_dout[7:0];
               region_q[s] <= ioctl_dout[15:8];
            end
            if (hit_cmpl[s]) cmpl_q[s] <= ioctl_dout;
            if (hit_csum[s]) begin
               csum_q[s] <= ioctl_dout;
               seen_q[s] <= 1'b1;
            end
         end
      end
   end

   // Image length decides copier offset and whether ExHiROM is plausible.
   logic [25:0] n_len;
   logic        copier, exhi_ok;
   assign n_len   = {1'b0, last_addr_q} + 26'd2;
   assign copier  = (n_len[9:0] == 10'h200);
   assign exhi_ok = n_len > (26'h400000 + (copier ? {1'b0, HDR_OFS} : 26'd0));

   logic [2:0] sel;
   logic [3:0] cur_score;
   assign sel = {1'b0, idx_q} + (copier ? 3'd3 : 3'd0);

   always_comb begin
      cur_score = 4'd0;
      if ((cmpl_q[sel] ^ csum_q[sel]) == 16'hFFFF)     cur_score = cur_score + 4'd8;
      if (mode_q[sel][3:0] == mode_of(idx_q))           cur_score = cur_score + 4'd4;
      if (rsize_q[sel] >= 8'h08 && rsize_q[sel] <= 8'h0D) cur_score = cur_score + 4'd2;
      if (ram_q[sel] <= 8'h07)                          cur_score = cur_score + 4'd1;
      if (!seen_q[sel] || (idx_q == 2'd2 && !exhi_ok))  cur_score = 4'd0;
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      load_out   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (fall) begin
               state_d    = EVAL;
               idx_d      = 2'd0;
               best_d     = 4'd0;
               best_idx_d = 2'd0;
            end
         end
         EVAL: begin
            if (rise) begin
               state_d = CAPTURE;
            end else begin
               if (cur_score > best_q) begin
                  best_d     = cur_score;
                  best_idx_d = idx_q;
               end
               if (idx_q == 2'd2) state_d = DONE;
               else               idx_d   = idx_q + 2'd1;
            end
         end
         DONE: begin
            if (rise) begin
               state_d = CAPTURE;
            end else begin
               load_out = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      old_dl_q <= ioctl_download;
      if (RESET) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         best_q      <= '0;
         best_idx_q  <= '0;
         last_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         if (clear_cap)   last_addr_q <= '0;
         else if (cap_en) last_addr_q <= ioctl_addr;
      end
   end

   // Winner decode: fallback values when no candidate is convincing.
   logic [2:0] win_slot;
   logic       win_ok;
   logic [3:0] rom_size_w, ram_size_w;
   logic [7:0] rom_type_w;
   logic       pal_w;
   assign win_slot = {1'b0, best_idx_q} + (copier ? 3'd3 : 3'd0);
   assign win_ok   = best_q >= MIN_S;

   always_comb begin
      rom_size_w = DEF_ROM_SIZE;
      ram_size_w = 4'd0;
      rom_type_w = 8'h00;
      pal_w      = 1'b0;
      if (win_ok) begin
         rom_size_w = (rsize_q[win_slot] > 8'h0D) ? 4'hD : rsize_q[win_slot][3:0];
         ram_size_w = (ram_q[win_slot] > 8'h07) ? 4'h7 : ram_q[win_slot][3:0];
         case (best_idx_q)
            2'd0:    rom_type_w = 8'h00;
            2'd1:    rom_type_w = 8'h01;
            default: rom_type_w = 8'h05;
         endcase
         pal_w = (region_q[win_slot] >= 8'h02) && (region_q[win_slot] <= 8'h0C);
      end
   end

   logic [7:0]  rom_type_q;
   logic [23:0] rom_mask_q, ram_mask_q;
   logic        rom_pal_q, hdr_copier_q, hdr_valid_q, hdr_done_q;
   logic [3:0]  best_score_q;

   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         rom_type_q   <= 8'h00;
         rom_mask_q   <= 24'h3FFFFF;
         ram_mask_q   <= 24'h0003FF;
         rom_pal_q    <= 1'b0;
         hdr_copier_q <= 1'b0;
         hdr_valid_q  <= 1'b0;
         hdr_done_q   <= 1'b0;
         best_score_q <= 4'd0;
      end else begin
         hdr_done_q <= load_out;
         if (clear_cap) hdr_valid_q <= 1'b0;
         if (load_out) begin
            rom_type_q   <= rom_type_w;
            rom_mask_q   <= (24'd1024 << rom_size_w) - 24'd1;
            ram_mask_q   <= (24'd1024 << ram_size_w) - 24'd1;
            rom_pal_q    <= pal_w;
            hdr_copier_q <= copier;
            hdr_valid_q  <= 1'b1;
            best_score_q <= best_q;
         end
      end
   end

   assign rom_type   = rom_type_q;
   assign rom_mask   = rom_mask_q;
   assign ram_mask   = ram_mask_q;
   assign rom_pal    = rom_pal_q;
   assign hdr_copier = hdr_copier_q;
   assign hdr_valid  = hdr_valid_q;
   assign hdr_done   = hdr_done_q;
   assign best_score = best_score_q;

endmodule

// File: tb/tb_rom_header_scanner.sv
// Directed bench for rom_header_scanner: sparse header writes per image,
// hand-computed mapping results and hdr_done latency.
`timescale 1ns/1ps
module tb_rom_header_scanner;

   logic        clk_sys = 1'b0;
   logic        RESET = 1'b1;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [15:0] ioctl_dout = '0;
   logic [7:0]  rom_type;
   logic [23:0] rom_mask, ram_mask;
   logic        rom_pal, hdr_copier, hdr_valid, hdr_done;
   logic [3:0]  best_score;

   int checks = 0;
   int failures = 0;

   rom_header_scanner dut (
      .clk_sys(clk_sys), .RESET(RESET), .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .rom_type(rom_type), .rom_mask(rom_mask), .ram_mask(ram_mask),
      .rom_pal(rom_pal), .hdr_copier(hdr_copier), .hdr_valid(hdr_valid),
      .hdr_done(hdr_done), .best_score(best_score)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic wr(input logic [24:0] a, input logic [15:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic hdr(input logic [24:0] b, input logic [7:0] mode, input logic [7:0] size,
                      input logic [7:0] ram, input logic [7:0] region,
                      input logic [15:0] cmpl, input logic [15:0] csum);
      wr(b + 25'h14, {mode, 8'h00});
      wr(b + 25'h16, {size, 8'h00});
      wr(b + 25'h18, {region, ram});
      wr(b + 25'h1C, cmpl);
      wr(b + 25'h1E, csum);
   endtask

   task automatic start_dl();
      ioctl_download = 1'b1;
      tick();
   endtask

   // Drops dl, then watches 12 cycles after edge T for the hdr_done pulse.
   task automatic end_dl(input string tag);
      int lat;
      int pulses;
      lat = -1;
      pulses = 0;
      ioctl_download = 1'b0;
      tick();
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (hdr_done) begin
            pulses++;
            if (lat < 0) lat = k;
         end
      end
      check({tag, "_latency"}, lat, 4);
      check({tag, "_pulses"}, pulses, 1);
   endtask

   task automatic expect_out(input string tag, input logic [7:0] ty, input logic [23:0] rm,
                             input logic [23:0] am, input logic pal, input logic cop,
                             input logic [3:0] sc);
      $display("image %s: type=%h rom_mask=%h ram_mask=%h pal=%0d copier=%0d score=%0d valid=%0d",
               tag, rom_type, rom_mask, ram_mask, rom_pal, hdr_copier, best_score, hdr_valid);
      check({tag, "_type"}, rom_type, ty);
      check({tag, "_rom_mask"}, rom_mask, rm);
      check({tag, "_ram_mask"}, ram_mask, am);
      check({tag, "_pal"}, rom_pal, pal);
      check({tag, "_copier"}, hdr_copier, cop);
      check({tag, "_score"}, best_score, sc);
      check({tag, "_valid"}, hdr_valid, 1'b1);
   endtask

   initial begin
      int seen_done;
      repeat (3) tick();
      RESET = 1'b0;
      tick();
      check("rst_type", rom_type, 8'h00);
      check("rst_rom_mask", rom_mask, 24'h3FFFFF);
      check("rst_ram_mask", ram_mask, 24'h0003FF);
      check("rst_pal", rom_pal, 1'b0);
      check("rst_copier", hdr_copier, 1'b0);
      check("rst_valid", hdr_valid, 1'b0);
      check("rst_done", hdr_done, 1'b0);
      check("rst_score", best_score, 4'd0);

      // LoROM 1MB, no copier
      start_dl();
      hdr(25'h7FC0, 8'h20, 8'h0A, 8'h03, 8'h01, 16'hEDCB, 16'h1234);
      wr(25'hFFFFE, 16'h0000);
      end_dl("lorom");
      expect_out("lorom", 8'h00, 24'h0FFFFF, 24'h001FFF, 1'b0, 1'b0, 4'd15);

      // HiROM 2MB + copier, header at 0x101C0
      start_dl();
      hdr(25'h101C0, 8'h21, 8'h0B, 8'h03, 8'h02, 16'h0F0F, 16'hF0F0);
      wr(25'h2001FE, 16'h0000);
      end_dl("hirom_cop");
      expect_out("hirom_cop", 8'h01, 24'h1FFFFF, 24'h001FFF, 1'b1, 1'b1, 4'd15);

      // Garbage: all-FF header words score 0 everywhere -> fallback
      start_dl();
      hdr(25'h7FC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF);
      hdr(25'hFFC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF);
      wr(25'hFFFFE, 16'hFFFF);
      end_dl("garbage");
      expect_out("garbage", 8'h00, 24'h3FFFFF, 24'h0003FF, 1'b0, 1'b0, 4'd0);

      // Lo and Hi both score 15 -> Lo wins the tie
      start_dl();
      hdr(25'h7FC0, 8'h20, 8'h09, 8'h01, 8'h00, 16'hFFFF, 16'h0000);
      hdr(25'hFFC0, 8'h21, 8'h0B, 8'h05, 8'h00, 16'h00FF, 16'hFF00);
      wr(25'h1FFFFE, 16'h0000);
      end_dl("tie");
      expect_out("tie", 8'h00, 24'h07FFFF, 24'h0007FF, 1'b0, 1'b0, 4'd15);

      // ExHiROM 6MB, size byte 0F clamps to D and misses the size bonus
      start_dl();
      hdr(25'h40FFC0, 8'h25, 8'h0F, 8'h07, 8'h0C, 16'h5AA5, 16'hA55A);
      wr(25'h5FFFFE, 16'h0000);
      end_dl("exhi");
      expect_out("exhi", 8'h05, 24'h7FFFFF, 24'h01FFFF, 1'b1, 1'b0, 4'd13);

      // Same ExHi header but image exactly 4MB -> not eligible
      start_dl();
      hdr(25'h40FFC0, 8'h25, 8'h0F, 8'h07, 8'h0C, 16'h5AA5, 16'hA55A);
      wr(25'h3FFFFE, 16'h0000);
      end_dl("exhi_4mb");
      expect_out("exhi_4mb", 8'h00, 24'h3FFFFF, 24'h0003FF, 1'b0, 1'b0, 4'd0);

      // Second download rises at T+2 of the first; first result must vanish
      start_dl();
      hdr(25'h7FC0, 8'h20, 8'h0A, 8'h03, 8'h01, 16'hEDCB, 16'h1234);
      wr(25'hFFFFE, 16'h0000);
      ioctl_download = 1'b0;
      tick();
      tick();
      ioctl_download = 1'b1;
      seen_done = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (hdr_done) seen_done++;
      end
      check("abort_no_done", seen_done, 0);
      check("abort_valid", hdr_valid, 1'b0);
      hdr(25'hFFC0, 8'h21, 8'h0A, 8'h02, 8'h0D, 16'h1111, 16'hEEEE);
      wr(25'hFFFFE, 16'h0000);
      end_dl("abort_2nd");
      expect_out("abort_2nd", 8'h01, 24'h0FFFFF, 24'h000FFF, 1'b0, 1'b0, 4'd15);

      // RESET mid-download, then dl falls: nothing reported
      start_dl();
      check("rise_clears_valid", hdr_valid, 1'b0);
      hdr(25'h7FC0, 8'h20, 8'h0A, 8'h03, 8'h01, 16'hEDCB, 16'h1234);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      wr(25'hFFFFE, 16'h0000);
      ioctl_download = 1'b0;
      seen_done = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (hdr_done) seen_done++;
      end
      $display("image reset_mid: done_pulses=%0d valid=%0d type=%h rom_mask=%h",
               seen_done, hdr_valid, rom_type, rom_mask);
      check("rstmid_no_done", seen_done, 0);
      check("rstmid_valid", hdr_valid, 1'b0);
      check("rstmid_type", rom_type, 8'h00);
      check("rstmid_rom_mask", rom_mask, 24'h3FFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
